seg7_scan_driver: RTL and testbench



---
 rtl/seg7_scan_driver.sv | 157 +++++++++++++++
 tb/tb_seg7_scan_driver.sv | 155 +++++++++++++++
 2 files changed

// File: rtl/seg7_scan_driver.sv
// Multiplexed multi-digit 7-segment scan driver with frame-synchronous value commit.
// Optional macro SEG7_LEADING_ZERO_BLANK_EN blanks leading zero digits (digit 0 never blanked).
module seg7_scan_driver #(
  parameter int DIGITS     = 4,
  parameter int CLK_DIV    = 1000,
  parameter int ACTIVE_LOW = 0
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                load,
  input  logic [5*DIGITS-1:0] value,
  output logic [6:0]          seg,
  output logic [DIGITS-1:0]   an,
  output logic                frame_tick,
  output logic                pending
);

  localparam int DW = $clog2(CLK_DIV);
  localparam int IW = $clog2(DIGITS);
  localparam logic [DW-1:0]     DIV_LAST = DW'(CLK_DIV - 1);
  localparam logic [IW-1:0]     IDX_LAST = IW'(DIGITS - 1);
  localparam logic [6:0]        SEG_INV  = (ACTIVE_LOW != 0) ? 7'h7F : 7'h00;
  localparam logic [DIGITS-1:0] AN_INV   = (ACTIVE_LOW != 0) ? {DIGITS{1'b1}} : {DIGITS{1'b0}};
  localparam logic [DIGITS-1:0] AN_DIG0  = {{(DIGITS-1){1'b0}}, 1'b1};

  logic [DW-1:0]       r_div;
  logic [IW-1:0]       r_idx;
  logic [5*DIGITS-1:0] r_disp;
  logic [5*DIGITS-1:0] r_pend_val;
  logic                r_pending;
  logic                r_frame_tick;
  logic [6:0]          r_seg;
  logic [DIGITS-1:0]   r_an;

  logic                w_div_last;
  logic                w_wrap;
  logic [4:0]          w_code;
  logic                w_lz_blank;
  logic [6:0]          w_seg_next;
  logic [DIGITS-1:0]   w_an_next;
`ifdef SEG7_LEADING_ZERO_BLANK_EN
  logic [DIGITS-1:0]   w_hi_blank;
`endif

  function automatic logic [6:0] f_decode(input logic [4:0] code);
    logic [6:0] s;
    case (code)
      5'd0:    s = 7'h7E;
      5'd1:    s = 7'h30;
      5'd2:    s = 7'h6D;
      5'd3:    s = 7'h79;
      5'd4:    s = 7'h33;
      5'd5:    s = 7'h5B;
      5'd6:    s = 7'h5F;
      5'd7:    s = 7'h70;
      5'd8:    s = 7'h7F;
      5'd9:    s = 7'h7B;
      5'd10:   s = 7'h77;
      5'd11:   s = 7'h1F;
      5'd12:   s = 7'h4E;
      5'd13:   s = 7'h3D;
      5'd14:   s = 7'h4F;
      5'd15:   s = 7'h47;
      5'd16:   s = 7'h01;
      default: s = 7'h00;
    endcase
    return s;
  endfunction

`ifdef SEG7_LEADING_ZERO_BLANK_EN
  function automatic logic f_zero_or_blank(input logic [4:0] code);
    return (code == 5'd0) || (code >= 5'd17);
  endfunction
`endif

  assign w_div_last = (r_div == DIV_LAST);
  assign w_wrap     = w_div_last && (r_idx == IDX_LAST);

  // Select the scanned digit's code and decide whether it is a blanked leading zero
  always_comb begin
    w_code     = 5'd31;
    w_lz_blank = 1'b0;
`ifdef SEG7_LEADING_ZERO_BLANK_EN
    w_hi_blank = {DIGITS{1'b0}};
    w_hi_blank[DIGITS-1] = 1'b1;
    for (int k = DIGITS - 2; k >= 0; k--) begin
      w_hi_blank[k] = w_hi_blank[k+1] & f_zero_or_blank(r_disp[5*(k+1) +: 5]);
    end
`endif
    for (int k = 0; k < DIGITS; k++) begin
      if (r_idx == IW'(k)) begin
        w_code = r_disp[5*k +: 5];
`ifdef SEG7_LEADING_ZERO_BLANK_EN
        w_lz_blank = (k != 0) && (r_disp[5*k +: 5] == 5'd0) && w_hi_blank[k];
`endif
      end else begin
        w_code = w_code;
      end
    end
    w_seg_next = w_lz_blank ? 7'h00 : f_decode(w_code);
    w_an_next  = AN_DIG0 << r_idx;
  end

  // Prescaler and digit index
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_div <= {DW{1'b0}};
      r_idx <= {IW{1'b0}};
    end else begin
      if (w_div_last) begin
        r_div <= {DW{1'b0}};
        r_idx <= (r_idx == IDX_LAST) ? {IW{1'b0}} : r_idx + IW'(1);
      end else begin
        r_div <= r_div + DW'(1);
      end
    end
  end

  // Pending capture and commit only at the frame boundary; a load on the wrap commits directly
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_disp       <= {DIGITS{5'd31}};
      r_pend_val   <= {(5*DIGITS){1'b0}};
      r_pending    <= 1'b0;
      r_frame_tick <= 1'b0;
    end else begin
      r_frame_tick <= w_wrap;
      if (load && w_wrap) begin
        r_disp    <= value;
        r_pending <= 1'b0;
      end else if (load) begin
        r_pend_val <= value;
        r_pending  <= 1'b1;
      end else if (w_wrap && r_pending) begin
        r_disp    <= r_pend_val;
        r_pending <= 1'b0;
      end
    end
  end

  // Output registers with board polarity applied
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_seg <= SEG_INV;
      r_an  <= AN_DIG0 ^ AN_INV;
    end else begin
      r_seg <= w_seg_next ^ SEG_INV;
      r_an  <= w_an_next ^ AN_INV;
    end
  end

  assign seg        = r_seg;
  assign an         = r_an;
  assign frame_tick = r_frame_tick;
  assign pending    = r_pending;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Table-driven bench for seg7_scan_driver (DIGITS=4, CLK_DIV=4), active-high and active-low instances.
module tb_seg7_scan_driver;

  logic        clk = 1'b0;
  logic        rst;
  logic        load, load_al;
  logic [19:0] value, value_al;
  logic [6:0]  seg, seg_al;
  logic [3:0]  an, an_al;
  logic        frame_tick, frame_tick_al;
  logic        pending, pending_al;

  int checks   = 0;
  int failures = 0;
  logic [6:0] u1_seg_exp;

  always #5 clk = ~clk;

  seg7_scan_driver #(.DIGITS(4), .CLK_DIV(4), .ACTIVE_LOW(0)) u_dut (
    .clk(clk), .rst(rst), .load(load), .value(value),
    .seg(seg), .an(an), .frame_tick(frame_tick), .pending(pending)
  );

  seg7_scan_driver #(.DIGITS(4), .CLK_DIV(4), .ACTIVE_LOW(1)) u_dut_al (
    .clk(clk), .rst(rst), .load(load_al), .value(value_al),
    .seg(seg_al), .an(an_al), .frame_tick(frame_tick_al), .pending(pending_al)
  );

  typedef struct {
    int               p1;
    logic [19:0]      v1;
    int               p2;
    logic [19:0]      v2;
    logic [3:0][6:0]  exp;
  } vec_t;

  vec_t tbl [8];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input int p, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s p=%0d actual=%0h expected=%0h t=%0t", nm, p, act, exp, $time);
    end
  endtask

  // One 16-cycle frame, p=1..16 after a frame boundary; prev is the content shown during it
  task automatic run_frame(input int p1, input logic [19:0] v1, input int p2,
                           input logic [19:0] v2, input logic [3:0][6:0] prev);
    for (int p = 1; p <= 16; p++) begin
      int d;
      logic [3:0] an_exp;
      d      = (p - 1) / 4;
      an_exp = 4'b0001 << d;
      if (p == p1) begin
        load  = 1'b1;
        value = v1;
      end else if (p2 != 0 && p == p2) begin
        load  = 1'b1;
        value = v2;
      end else begin
        load = 1'b0;
      end
      step();
      load = 1'b0;
      chk("seg", p, {25'd0, seg}, {25'd0, prev[d]});
      chk("an", p, {28'd0, an}, {28'd0, an_exp});
      chk("frame_tick", p, {31'd0, frame_tick}, {31'd0, (p == 16)});
      chk("pending", p, {31'd0, pending}, {31'd0, (p1 != 0 && p >= p1 && p < 16)});
      chk("seg_al", p, {25'd0, seg_al}, {25'd0, u1_seg_exp});
      chk("an_al", p, {28'd0, an_al}, {28'd0, ~an_exp});
    end
  endtask

  initial begin
    logic [6:0]      z;
    logic [3:0][6:0] prev;
    logic [3:0][6:0] blank;
`ifdef SEG7_LEADING_ZERO_BLANK_EN
    z = 7'h00;
`else
    z = 7'h7E;
`endif
    blank = {4{7'h00}};

    tbl[0] = '{p1:4,  v1:{5'd1, 5'd2, 5'd3, 5'd4},     p2:0, v2:20'd0,        exp:{7'h30, 7'h6D, 7'h79, 7'h33}};
    tbl[1] = '{p1:2,  v1:{4{5'd5}},                    p2:9, v2:{4{5'd8}},    exp:{4{7'h7F}}};
    tbl[2] = '{p1:16, v1:{5'd15, 5'd14, 5'd13, 5'd12}, p2:0, v2:20'd0,        exp:{7'h47, 7'h4F, 7'h3D, 7'h4E}};
    tbl[3] = '{p1:7,  v1:{5'd16, 5'd17, 5'd31, 5'd5},  p2:0, v2:20'd0,        exp:{7'h01, 7'h00, 7'h00, 7'h5B}};
    tbl[4] = '{p1:5,  v1:{5'd0, 5'd0, 5'd7, 5'd0},     p2:0, v2:20'd0,        exp:{z, z, 7'h70, 7'h7E}};
    tbl[5] = '{p1:10, v1:{5'd0, 5'd16, 5'd0, 5'd0},    p2:0, v2:20'd0,        exp:{z, 7'h01, 7'h7E, 7'h7E}};
    tbl[6] = '{p1:1,  v1:{5'd6, 5'd9, 5'd10, 5'd11},   p2:0, v2:20'd0,        exp:{7'h5F, 7'h7B, 7'h77, 7'h1F}};
    tbl[7] = '{p1:3,  v1:{4{5'd0}},                    p2:0, v2:20'd0,        exp:{z, z, z, 7'h7E}};

    rst = 1'b1; load = 1'b0; value = 20'd0; load_al = 1'b0; value_al = 20'd0;
    u1_seg_exp = 7'h7F;
    step();
    step();
    chk("rst_seg", 0, {25'd0, seg}, 32'h00);
    chk("rst_an", 0, {28'd0, an}, 32'h1);
    chk("rst_tick", 0, {31'd0, frame_tick}, 32'h0);
    chk("rst_pending", 0, {31'd0, pending}, 32'h0);
    chk("rst_seg_al", 0, {25'd0, seg_al}, 32'h7F);
    chk("rst_an_al", 0, {28'd0, an_al}, 32'hE);

    rst = 1'b0;
    load_al  = 1'b1;
    value_al = {4{5'd16}};
    step();
    load_al = 1'b0;
    chk("pending_al", 1, {31'd0, pending_al}, 32'h1);
    for (int i = 2; i <= 16; i++) step();
    chk("first_tick", 16, {31'd0, frame_tick}, 32'h1);
    chk("first_tick_al", 16, {31'd0, frame_tick_al}, 32'h1);
    u1_seg_exp = 7'h7E;

    prev = blank;
    for (int i = 0; i < 8; i++) begin
      run_frame(tbl[i].p1, tbl[i].v1, tbl[i].p2, tbl[i].v2, prev);
      prev = tbl[i].exp;
    end
    run_frame(0, 20'd0, 0, 20'd0, prev);

    // Mid-frame reset discards an uncommitted value
    load  = 1'b1;
    value = {4{5'd8}};
    step();
    load = 1'b0;
    chk("pre_rst_pending", 1, {31'd0, pending}, 32'h1);
    step();
    step();
    rst = 1'b1;
    #1;
    chk("async_rst_pending", 0, {31'd0, pending}, 32'h0);
    chk("async_rst_seg", 0, {25'd0, seg}, 32'h00);
    chk("async_rst_an", 0, {28'd0, an}, 32'h1);
    chk("async_rst_seg_al", 0, {25'd0, seg_al}, 32'h7F);
    chk("async_rst_an_al", 0, {28'd0, an_al}, 32'hE);
    step();
    step();
    rst = 1'b0;
    u1_seg_exp = 7'h7F;
    run_frame(0, 20'd0, 0, 20'd0, blank);
    run_frame(0, 20'd0, 0, 20'd0, blank);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
